// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60) and small helpers for the
// horizontal and vertical timing blocks.
package vga_timing_pkg;

   localparam int   COUNT_W          = 16;

   localparam int   VGA_H_VISIBLE    = 640;
   localparam int   VGA_H_FRONT      = 16;
   localparam int   VGA_H_SYNC       = 96;
   localparam int   VGA_H_BACK       = 48;
   localparam int   VGA_H_TOTAL      = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
   localparam logic VGA_HSYNC_ACTIVE = 1'b0;

   localparam int   VGA_V_VISIBLE    = 480;
   localparam int   VGA_V_FRONT      = 10;
   localparam int   VGA_V_SYNC       = 2;
   localparam int   VGA_V_BACK       = 33;
   localparam int   VGA_V_TOTAL      = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
   localparam logic VGA_VSYNC_ACTIVE = 1'b0;

   typedef logic [COUNT_W-1:0] count_t;

   // Half-open window test [lo, hi) on a column/row value.
   function automatic logic in_window(count_t c, count_t lo, count_t hi);
      return (c >= lo) && (c < hi);
   endfunction

endpackage

// File: rtl/h_timing_gen_if.sv
// Horizontal timing bundle: run control in, pixel strobe/column/decodes out.
interface h_timing_gen_if;
   import vga_timing_pkg::*;

   logic   enable;
   logic   pixel_tick;
   count_t h_count;
   logic   v_count_enable;
   logic   hsync;
   logic   h_video_on;

   modport master (input  enable,
                   output pixel_tick, h_count, v_count_enable, hsync, h_video_on);
   modport slave  (output enable,
                   input  pixel_tick, h_count, v_count_enable, hsync, h_video_on);
endinterface

// File: rtl/pixel_tick_div.sv
// System-clock to pixel-rate divider; pix_edge marks the edge that advances
// the column, pixel_tick is its registered one-clk strobe.
module pixel_tick_div
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic pix_edge,
   output logic pixel_tick
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_cnt;

   assign pix_edge = enable && (div_cnt == DIV_LAST);

   // Phase is held while disabled so resuming neither skips nor repeats a tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt    <= '0;
         pixel_tick <= 1'b0;
      end else if (pix_edge) begin
         div_cnt    <= '0;
         pixel_tick <= 1'b1;
      end else begin
         if (enable) div_cnt <= div_cnt + DW'(1);
         pixel_tick <= 1'b0;
      end
   end

endmodule

// File: rtl/h_timing_gen.sv
// Horizontal VGA timing: pixel divider, 0..H_TOTAL-1 column counter,
// registered hsync / h_video_on and the end-of-line v_count_enable pulse.
module h_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   CLK_DIV      = 4,
   parameter int   H_VISIBLE    = VGA_H_VISIBLE,
   parameter int   H_FRONT      = VGA_H_FRONT,
   parameter int   H_SYNC       = VGA_H_SYNC,
   parameter int   H_BACK       = VGA_H_BACK,
   parameter logic HSYNC_ACTIVE = VGA_HSYNC_ACTIVE
) (
   input  logic           clk,
   input  logic           reset,
   h_timing_gen_if.master hif
);
   localparam int     H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam count_t LAST_COL = count_t'(H_TOTAL - 1);
   localparam count_t VIS_END  = count_t'(H_VISIBLE);
   localparam count_t SYNC_LO  = count_t'(H_VISIBLE + H_FRONT);
   localparam count_t SYNC_HI  = count_t'(H_VISIBLE + H_FRONT + H_SYNC);

   logic   pix_edge;
   logic   pixel_tick;
   count_t h_count;
   count_t h_next;
   logic   wrap;
   logic   v_count_enable;
   logic   hsync;
   logic   h_video_on;

   pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk        (clk),
      .reset      (reset),
      .enable     (hif.enable),
      .pix_edge   (pix_edge),
      .pixel_tick (pixel_tick)
   );

   always_comb begin
      wrap   = (h_count == LAST_COL);
      h_next = wrap ? '0 : h_count + count_t'(1);
   end

   // Decodes come from h_next so they land on the same edge as the column.
   always_ff @(posedge clk) begin
      if (reset) begin
         h_count        <= '0;
         v_count_enable <= 1'b0;
         hsync          <= ~HSYNC_ACTIVE;
         h_video_on     <= 1'b0;
      end else if (pix_edge) begin
         h_count        <= h_next;
         v_count_enable <= wrap;
         hsync          <= in_window(h_next, SYNC_LO, SYNC_HI) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
         h_video_on     <= (h_next < VIS_END);
      end else begin
         v_count_enable <= 1'b0;
      end
   end

   assign hif.pixel_tick     = pixel_tick;
   assign hif.h_count        = h_count;
   assign hif.v_count_enable = v_count_enable;
   assign hif.hsync          = hsync;
   assign hif.h_video_on     = h_video_on;

endmodule

// File: tb/tb_h_timing_gen.sv
// Scoreboarded bench for h_timing_gen at CLK_DIV=4 and CLK_DIV=1, plus
// directed line-structure, freeze/resume and mid-line reset checks.
module tb_h_timing_gen;
   import vga_timing_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   h_timing_gen_if hif0 ();
   h_timing_gen_if hif1 ();

   h_timing_gen #(.CLK_DIV(4)) dut0 (.clk(clk), .reset(reset), .hif(hif0.master));
   h_timing_gen #(.CLK_DIV(1)) dut1 (.clk(clk), .reset(reset), .hif(hif1.master));

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;
   int q0[$];
   int q1[$];

   // reference state, index 0 = CLK_DIV 4, 1 = CLK_DIV 1
   int m_div [2];
   int m_h   [2];
   bit m_tick[2];
   bit m_vce [2];
   bit m_hs  [2];
   bit m_von [2];

   // line measurement
   bit meas = 1'b0;
   bit seen0 = 1'b0, seen1 = 1'b0;
   int last0, last1, hs_cnt, von_cnt, nlines0 = 0, ngap1 = 0;
   int vcnt;

   // bench vertical counter: advances the edge after each end-of-line pulse
   always @(posedge clk) begin
      if (reset) vcnt <= 0;
      else if (hif0.v_count_enable) vcnt <= vcnt + 1;
   end

   task automatic chk(input string tag, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
      end
   endtask

   function automatic int pack(bit t, bit v, bit hs, bit vo, int h);
      return (int'(t) << 19) | (int'(v) << 18) | (int'(hs) << 17) | (int'(vo) << 16) | (h & 'hffff);
   endfunction

   function automatic int obs(int id);
      if (id == 0)
         return pack(hif0.pixel_tick, hif0.v_count_enable, hif0.hsync, hif0.h_video_on, int'(hif0.h_count));
      return pack(hif1.pixel_tick, hif1.v_count_enable, hif1.hsync, hif1.h_video_on, int'(hif1.h_count));
   endfunction

   task automatic model(input int id, input int cd, input bit rst, input bit en);
      int e;
      if (rst) begin
         m_div[id] = 0; m_h[id] = 0; m_tick[id] = 0; m_vce[id] = 0; m_hs[id] = 1; m_von[id] = 0;
      end else if (en && m_div[id] == cd - 1) begin
         m_div[id]  = 0;
         m_tick[id] = 1;
         m_vce[id]  = (m_h[id] == 799);
         m_h[id]    = m_vce[id] ? 0 : m_h[id] + 1;
         m_hs[id]   = !(m_h[id] >= 656 && m_h[id] <= 751);
         m_von[id]  = (m_h[id] <= 639);
      end else begin
         if (en) m_div[id] = m_div[id] + 1;
         m_tick[id] = 0;
         m_vce[id]  = 0;
      end
      e = pack(m_tick[id], m_vce[id], m_hs[id], m_von[id], m_h[id]);
      if (id == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   task automatic monitor();
      if (!meas) return;
      if (hif0.pixel_tick) begin
         if (hif0.v_count_enable) begin
            if (seen0) begin
               chk("line_gap", cyc - last0, 3200);
               chk("hs_low", hs_cnt, 96);
               chk("vid_on", von_cnt, 640);
               nlines0++;
            end
            seen0 = 1; last0 = cyc; hs_cnt = 0; von_cnt = 0;
         end
         if (!hif0.hsync) hs_cnt++;
         if (hif0.h_video_on) von_cnt++;
      end
      if (hif1.v_count_enable) begin
         if (seen1) begin
            chk("gap_div1", cyc - last1, 800);
            ngap1++;
         end
         seen1 = 1; last1 = cyc;
      end
   endtask

   task automatic step(input bit rst, input bit en);
      reset       = rst;
      hif0.enable = en;
      hif1.enable = en;
      model(0, 4, rst, en);
      model(1, 1, rst, en);
      @(posedge clk);
      #1;
      cyc++;
      if (q0.size() == 0) chk("sb0_empty", 0, 1);
      else chk("sb0", obs(0), q0.pop_front());
      if (q1.size() == 0) chk("sb1_empty", 0, 1);
      else chk("sb1", obs(1), q1.pop_front());
      monitor();
   endtask

   task automatic run_until(input int col, output bit found);
      found = 1'b0;
      for (int i = 0; i < 4000 && !found; i++) begin
         step(1'b0, 1'b1);
         if (hif0.pixel_tick && int'(hif0.h_count) == col) found = 1'b1;
      end
      if (!found) chk("timeout", col, -1);
   endtask

   initial begin
      bit found;
      int k, n, snap;
      reset = 1'b1; hif0.enable = 1'b0; hif1.enable = 1'b0;

      // reset overrides enable
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      cyc = 0;

      // first three pixel edges at clks 4, 8, 12 with columns 1, 2, 3
      k = 1;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b1);
         if (hif0.pixel_tick) begin
            chk("tick_at", cyc, 4 * k);
            chk("tick_h", int'(hif0.h_count), k);
            k++;
         end
      end
      chk("tick_n", k - 1, 3);

      // three line wraps: spacing, hsync/video widths, vertical advance
      meas = 1'b1;
      while (cyc < 9610) step(1'b0, 1'b1);
      meas = 1'b0;
      chk("vcnt", vcnt, 3);
      chk("lines0", nlines0, 2);
      chk("gaps1", ngap1, 11);

      // freeze at column 300 with divider phase 2
      run_until(300, found);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      snap = obs(0);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0);
         chk("frz", obs(0), snap);
      end
      n = 0;
      do begin
         step(1'b0, 1'b1);
         n++;
      end while (!hif0.pixel_tick && n < 8);
      chk("resume_n", n, 2);
      chk("resume_h", int'(hif0.h_count), 301);

      // mid-sync reset
      run_until(700, found);
      chk("pre_hs", int'(hif0.hsync), 0);
      step(1'b1, 1'b1);
      chk("rst_h", int'(hif0.h_count), 0);
      chk("rst_hs", int'(hif0.hsync), 1);
      chk("rst_von", int'(hif0.h_video_on), 0);
      chk("rst_tick", int'(hif0.pixel_tick), 0);
      chk("rst_vce", int'(hif0.v_count_enable), 0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
